// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core (AES-128/192/256 via Nk), one round per clock, valid/ready I/O.
// Optional: define AES_CIPHER_KEY_LATCH_EN to capture the key schedule into a register on accept.
module aes_cipher_iter #(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = Nk + 6
) (
    input  logic                  clks,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:127]          plain_text,
    input  logic [0:128*(Nr+1)-1] keys,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:127]          cipher_text,
    output logic                  busy
);

    if (!((Nk == 4 || Nk == 6 || Nk == 8) && Nr == Nk + 6)) begin : g_bad_param
        $error("aes_cipher_iter: Nk must be 4, 6 or 8 and Nr must equal Nk + 6");
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0), followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gmul(inv, inv);
            if (i != 0) inv = gmul(inv, a);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Byte (row r, column c) lives at bits [32*c + 8*r +: 8], MSB first.
    function automatic logic [0:127] sub_shift(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[32*c + 8*r +: 8] = sbox(s[32*((c + r) % 4) + 8*r +: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [0:127]            r_st;
    logic [3:0]              r_rnd;
    logic [0:127]            r_ct;
    logic [0:128*(Nr+1)-1]   w_keys;
    logic [0:127]            w_rk [Nr+1];
    logic [0:127]            w_sr;
    logic [0:127]            w_mc;
    logic [0:127]            w_round;
    logic                    w_accept;

    assign w_accept = (r_state == StIdle) && in_valid;

`ifdef AES_CIPHER_KEY_LATCH_EN
    logic [0:128*(Nr+1)-1] r_keys;

    always_ff @(posedge clks) begin
        if (reset) begin
            r_keys <= '0;
        end else if (w_accept) begin
            r_keys <= keys;
        end
    end

    assign w_keys = r_keys;
`else
    assign w_keys = keys;
`endif

    for (genvar r = 0; r <= Nr; r++) begin : g_rk
        assign w_rk[r] = w_keys[128*r +: 128];
    end

    // Single shared round datapath; the final round skips MixColumns.
    assign w_sr    = sub_shift(r_st);
    assign w_mc    = mix_columns(w_sr);
    assign w_round = ((r_state == StFinal) ? w_sr : w_mc) ^ w_rk[r_rnd];

    always_ff @(posedge clks) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (in_valid) w_state_nxt = StRound;
            StRound: if (r_rnd == 4'(Nr - 1)) w_state_nxt = StFinal;
            StFinal: w_state_nxt = StDone;
            StDone:  if (out_ready) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == StIdle);
        busy      = (r_state == StRound) || (r_state == StFinal);
        out_valid = (r_state == StDone);
    end

    // Key 0 is taken straight from the input: any key register only loads on this same edge.
    always_ff @(posedge clks) begin
        if (reset) begin
            r_st  <= '0;
            r_rnd <= '0;
            r_ct  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_st  <= plain_text ^ keys[0 +: 128];
                        r_rnd <= 4'd1;
                    end
                end
                StRound: begin
                    r_st  <= w_round;
                    r_rnd <= r_rnd + 4'd1;
                end
                StFinal: r_ct <= w_round;
                default: ;
            endcase
        end
    end

    assign cipher_text = r_ct;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Scoreboard bench for aes_cipher_iter: AES-128/192/256 instances driven with FIPS-197 vectors.
module tb_aes_cipher_iter;

    logic clks = 1'b0;
    always #5 clks = ~clks;

    logic                    reset;
    logic [2:0]              iv;
    logic [2:0]              ordy;
    logic [2:0]              ir;
    logic [2:0]              ov;
    logic [2:0]              bz;
    logic [2:0][127:0]       ptv;
    logic [2:0][127:0]       ctv;
    logic [0:128*11-1]       k128;
    logic [0:128*13-1]       k192;
    logic [0:128*15-1]       k256;
    logic [0:128*15-1]       sched;

    aes_cipher_iter #(.Nk(4)) u_aes128 (
        .clks(clks), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .plain_text(ptv[0]),
        .keys(k128), .out_valid(ov[0]), .out_ready(ordy[0]), .cipher_text(ctv[0]), .busy(bz[0])
    );
    aes_cipher_iter #(.Nk(6)) u_aes192 (
        .clks(clks), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .plain_text(ptv[1]),
        .keys(k192), .out_valid(ov[1]), .out_ready(ordy[1]), .cipher_text(ctv[1]), .busy(bz[1])
    );
    aes_cipher_iter #(.Nk(8)) u_aes256 (
        .clks(clks), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .plain_text(ptv[2]),
        .keys(k256), .out_valid(ov[2]), .out_ready(ordy[2]), .cipher_text(ctv[2]), .busy(bz[2])
    );

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic [7:0] sbox_t [256] = '{
        'h63,'h7c,'h77,'h7b,'hf2,'h6b,'h6f,'hc5,'h30,'h01,'h67,'h2b,'hfe,'hd7,'hab,'h76,
        'hca,'h82,'hc9,'h7d,'hfa,'h59,'h47,'hf0,'had,'hd4,'ha2,'haf,'h9c,'ha4,'h72,'hc0,
        'hb7,'hfd,'h93,'h26,'h36,'h3f,'hf7,'hcc,'h34,'ha5,'he5,'hf1,'h71,'hd8,'h31,'h15,
        'h04,'hc7,'h23,'hc3,'h18,'h96,'h05,'h9a,'h07,'h12,'h80,'he2,'heb,'h27,'hb2,'h75,
        'h09,'h83,'h2c,'h1a,'h1b,'h6e,'h5a,'ha0,'h52,'h3b,'hd6,'hb3,'h29,'he3,'h2f,'h84,
        'h53,'hd1,'h00,'hed,'h20,'hfc,'hb1,'h5b,'h6a,'hcb,'hbe,'h39,'h4a,'h4c,'h58,'hcf,
        'hd0,'hef,'haa,'hfb,'h43,'h4d,'h33,'h85,'h45,'hf9,'h02,'h7f,'h50,'h3c,'h9f,'ha8,
        'h51,'ha3,'h40,'h8f,'h92,'h9d,'h38,'hf5,'hbc,'hb6,'hda,'h21,'h10,'hff,'hf3,'hd2,
        'hcd,'h0c,'h13,'hec,'h5f,'h97,'h44,'h17,'hc4,'ha7,'h7e,'h3d,'h64,'h5d,'h19,'h73,
        'h60,'h81,'h4f,'hdc,'h22,'h2a,'h90,'h88,'h46,'hee,'hb8,'h14,'hde,'h5e,'h0b,'hdb,
        'he0,'h32,'h3a,'h0a,'h49,'h06,'h24,'h5c,'hc2,'hd3,'hac,'h62,'h91,'h95,'he4,'h79,
        'he7,'hc8,'h37,'h6d,'h8d,'hd5,'h4e,'ha9,'h6c,'h56,'hf4,'hea,'h65,'h7a,'hae,'h08,
        'hba,'h78,'h25,'h2e,'h1c,'ha6,'hb4,'hc6,'he8,'hdd,'h74,'h1f,'h4b,'hbd,'h8b,'h8a,
        'h70,'h3e,'hb5,'h66,'h48,'h03,'hf6,'h0e,'h61,'h35,'h57,'hb9,'h86,'hc1,'h1d,'h9e,
        'he1,'hf8,'h98,'h11,'h69,'hd9,'h8e,'h94,'h9b,'h1e,'h87,'he9,'hce,'h55,'h28,'hdf,
        'h8c,'ha1,'h89,'h0d,'hbf,'he6,'h42,'h68,'h41,'h99,'h2d,'h0f,'hb0,'h54,'hbb,'h16
    };

    typedef struct {
        int           idx;
        logic [127:0] ct;
        int           t_acc;
    } exp_t;

    exp_t       exp_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         last_acc = 0;
    logic [2:0] ov_prev  = '0;

    always @(posedge clks) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic int nr_of(input int i);
        return 10 + 2 * i;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Key bytes are 00, 01, 02, ... ; result is the flat schedule, round key r at [128*r +: 128].
    task automatic expand(input int nk, output logic [0:128*15-1] s);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nw;
        nw = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        for (int i = nk; i < 60; i++) w[i] = '0;
        rc = 8'h01;
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        s = '0;
        for (int i = 0; i < nw; i++) s[32*i +: 32] = w[i];
    endtask

    // Monitor: each rising out_valid pops one expectation and checks instance, data and latency.
    always @(negedge clks) begin
        for (int i = 0; i < 3; i++) begin
            if (ov[i] && !ov_prev[i]) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_out_valid: instance %0d raised out_valid, none expected", i);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result_instance", 128'(i), 128'(e.idx));
                    check("cipher_text", ctv[i], e.ct);
                    check("latency", 128'(cyc - e.t_acc), 128'(nr_of(i)));
                end
            end
        end
        ov_prev <= ov;
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input int i, input logic [127:0] p, input logic [127:0] ex, input bit push);
        int n;
        n = 0;
        while (!ir[i] && n < 100) begin
            @(negedge clks);
            n++;
        end
        check("in_ready_before_send", ir[i], 1);
        ptv[i] = p;
        iv[i]  = 1'b1;
        if (push) exp_q.push_back('{idx: i, ct: ex, t_acc: cyc + 1});
        last_acc = cyc + 1;
        @(negedge clks);
        iv[i] = 1'b0;
    endtask

    task automatic wait_ov(input int i);
        int n;
        n = 0;
        while (!ov[i] && n < 50) begin
            @(negedge clks);
            n++;
        end
        check("wait_out_valid", ov[i], 1);
    endtask

    task automatic check_reset_vals(input string tag);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_in_ready"}, ir[i], 1);
            check({tag, "_out_valid"}, ov[i], 0);
            check({tag, "_busy"}, bz[i], 0);
            check({tag, "_cipher_text"}, ctv[i], 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int t1;
        reset = 1'b1;
        iv    = '0;
        ordy  = '1;
        ptv   = '0;
        expand(4, sched);
        k128 = sched[0 +: 128*11];
        expand(6, sched);
        k192 = sched[0 +: 128*13];
        expand(8, sched);
        k256 = sched[0 +: 128*15];
        repeat (3) @(negedge clks);
        reset = 1'b0;
        @(negedge clks);
        check_reset_vals("reset");

        // AES-128, then a second block to measure throughput with out_ready high.
        send(0, PT, C128, 1);
        check("busy_after_accept", bz[0], 1);
        check("in_ready_while_busy", ir[0], 0);
        t1 = last_acc;
        wait_ov(0);
        send(0, PT, C128, 1);
        check("throughput_period", 128'(last_acc - t1), 128'(12));
        wait_ov(0);
        @(negedge clks);
        check("done_one_cycle_out_valid", ov[0], 0);
        check("done_one_cycle_in_ready", ir[0], 1);

        send(1, PT, C192, 1);
        wait_ov(1);
        send(2, PT, C256, 1);
        wait_ov(2);
        @(negedge clks);

        // Backpressure: result held for 20 cycles.
        ordy[0] = 1'b0;
        send(0, PT, C128, 1);
        wait_ov(0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clks);
            check("bp_out_valid", ov[0], 1);
            check("bp_in_ready", ir[0], 0);
            check("bp_cipher_text", ctv[0], C128);
        end
        ordy[0] = 1'b1;
        @(negedge clks);
        check("bp_release_in_ready", ir[0], 1);
        check("bp_release_out_valid", ov[0], 0);

        // in_valid pulsed while busy must be ignored.
        send(0, PT, C128, 1);
        repeat (3) @(negedge clks);
        ptv[0] = 128'hdeadbeef_00000000_cafef00d_12345678;
        iv[0]  = 1'b1;
        @(negedge clks);
        iv[0]  = 1'b0;
        wait_ov(0);
        repeat (15) @(negedge clks);
        check("ignored_in_ready", ir[0], 1);
        check("ignored_busy", bz[0], 0);

        // Reset at round 5 aborts the block.
        send(0, PT, C128, 0);
        repeat (4) @(negedge clks);
        check("abort_busy_before_reset", bz[0], 1);
        reset = 1'b1;
        @(negedge clks);
        reset = 1'b0;
        check_reset_vals("abort");
        repeat (20) @(negedge clks);
        check("abort_no_out_valid", ov[0], 0);
        check("abort_idle", ir[0], 1);

`ifdef AES_CIPHER_KEY_LATCH_EN
        send(0, PT, C128, 1);
        k128 = ~k128;
        wait_ov(0);
        @(negedge clks);
        k128 = ~k128;
`endif

        repeat (2) @(negedge clks);
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
